// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fp_pkg
// Description : Shared FP32 types, constants and helpers for the dense-layer
//               accumulation datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    // IEEE-754 single-precision field view
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

    localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

    // Alignment field: hidden bit + 23 fraction bits + 27 guard bits. The guard
    // bits plus a jammed sticky keep truncation exact for every exponent gap.
    localparam int FP_ALIGN_W = 51;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } acc_state_t;

    // Leading-zero count over the alignment field (all-zero input returns width)
    function automatic logic [5:0] fp_lzc(input logic [FP_ALIGN_W-1:0] v);
        logic [5:0] cnt;
        cnt = 6'(FP_ALIGN_W);
        for (int i = 0; i < FP_ALIGN_W; i++) begin
            if (v[i]) begin
                cnt = 6'(FP_ALIGN_W - 1 - i);
            end
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_accum_ctrl_flp_adder.sv
`default_nettype none
// ============================================================================
// Module      : flp_adder
// Description : Combinational FP32 adder. Zero operands (exponent 0) bypass
//               the datapath, denormal results flush to +0.0, rounding is by
//               truncation toward zero, overflow saturates to infinity.
// Revision    : 1.0 - initial release
// ============================================================================
module flp_adder
    import fp_pkg::*;
(
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    output logic [31:0] o_sum
);

    localparam int c_guard_w = FP_ALIGN_W - 24;
    localparam logic [FP_ALIGN_W-1:0] c_align_one = {{(FP_ALIGN_W-1){1'b0}}, 1'b1};

    fp32_t                 w_a;
    fp32_t                 w_b;
    fp32_t                 w_big;
    fp32_t                 w_small;
    logic                  w_a_nan;
    logic                  w_b_nan;
    logic                  w_eff_sub;
    logic [7:0]            w_diff;
    logic [FP_ALIGN_W-1:0] w_big_m;
    logic [FP_ALIGN_W-1:0] w_small_m;
    logic [FP_ALIGN_W-1:0] w_mask;
    logic [FP_ALIGN_W-1:0] w_aligned;
    logic [FP_ALIGN_W-1:0] w_norm;
    logic [FP_ALIGN_W:0]   w_raw;
    logic [5:0]            w_lz;
    logic signed [9:0]     w_exp;
    logic [31:0]           w_sum;

    assign w_a   = fp32_t'(num1);
    assign w_b   = fp32_t'(num2);
    assign o_sum = w_sum;

    // Classify operands, then align, add/subtract, normalise and truncate
    always_comb begin
        w_big     = w_a;
        w_small   = w_b;
        w_diff    = 8'd0;
        w_big_m   = '0;
        w_small_m = '0;
        w_mask    = '0;
        w_aligned = '0;
        w_raw     = '0;
        w_norm    = '0;
        w_lz      = 6'd0;
        w_exp     = 10'sd0;
        w_eff_sub = 1'b0;
        w_sum     = FP_ZERO;
        w_a_nan   = (w_a.exp == FP_EXP_MAX) && (w_a.mant != 23'd0);
        w_b_nan   = (w_b.exp == FP_EXP_MAX) && (w_b.mant != 23'd0);

        if ((w_a.exp == FP_EXP_MAX) || (w_b.exp == FP_EXP_MAX)) begin
            // Special operands: NaN propagates, opposing infinities make NaN
            if (w_a_nan || w_b_nan) begin
                w_sum = FP_QNAN;
            end else if ((w_a.exp == FP_EXP_MAX) && (w_b.exp == FP_EXP_MAX) &&
                         (w_a.sign != w_b.sign)) begin
                w_sum = FP_QNAN;
            end else if (w_a.exp == FP_EXP_MAX) begin
                w_sum = num1;
            end else begin
                w_sum = num2;
            end
        end else if (w_a.exp == 8'd0) begin
            w_sum = num2;
        end else if (w_b.exp == 8'd0) begin
            w_sum = num1;
        end else begin
            // Larger magnitude operand sets the result sign and exponent
            if ({w_b.exp, w_b.mant} > {w_a.exp, w_a.mant}) begin
                w_big   = w_b;
                w_small = w_a;
            end
            w_diff    = w_big.exp - w_small.exp;
            w_big_m   = {1'b1, w_big.mant, {c_guard_w{1'b0}}};
            w_small_m = {1'b1, w_small.mant, {c_guard_w{1'b0}}};
            // Shift amounts beyond the field width yield an all-ones mask
            w_mask    = (c_align_one << w_diff) - c_align_one;
            w_aligned = (w_small_m >> w_diff) |
                        {{(FP_ALIGN_W-1){1'b0}}, |(w_small_m & w_mask)};
            w_eff_sub = w_a.sign ^ w_b.sign;

            if (w_eff_sub) begin
                w_raw = {1'b0, w_big_m} - {1'b0, w_aligned};
            end else begin
                w_raw = {1'b0, w_big_m} + {1'b0, w_aligned};
            end

            if (w_raw[FP_ALIGN_W]) begin
                w_norm = w_raw[FP_ALIGN_W:1];
                w_exp  = $signed({2'b00, w_big.exp}) + 10'sd1;
            end else begin
                w_lz   = fp_lzc(w_raw[FP_ALIGN_W-1:0]);
                w_norm = w_raw[FP_ALIGN_W-1:0] << w_lz;
                w_exp  = $signed({2'b00, w_big.exp}) - $signed({4'b0000, w_lz});
            end

            if (w_raw == '0) begin
                w_sum = FP_ZERO;
            end else if (w_exp >= 10'sd255) begin
                w_sum = {w_big.sign, FP_EXP_MAX, 23'd0};
            end else if (w_exp <= 10'sd0) begin
                w_sum = FP_ZERO;
            end else begin
                w_sum = {w_big.sign, w_exp[7:0], w_norm[FP_ALIGN_W-2 -: 23]};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fp_accum_ctrl
// Description : Reduces a streamed FP32 vector (one element per cycle over
//               valid/ready) to a single sum held on a valid/ready output.
//               Optional build macro FP_ACC_RELU_EN clamps negative results
//               to +0.0 on out_data.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_accum_ctrl
    import fp_pkg::*;
#(
    parameter int LEN_W = 10
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             inf_nan
);

    localparam logic [LEN_W-1:0] c_len_one = {{(LEN_W-1){1'b0}}, 1'b1};

    acc_state_t       r_state;
    acc_state_t       w_next_state;
    logic [31:0]      r_acc;
    logic [LEN_W-1:0] r_count;
    logic [LEN_W-1:0] r_len;
    logic             r_inf_nan;
    logic [31:0]      r_out_hold;
    logic [31:0]      w_sum;
    fp32_t            w_sum_f;
    logic [31:0]      w_result;
    logic             w_last_beat;

    // Accumulator feeds back as num1; the seed of +0.0 makes the first element pass through
    flp_adder u_flp_adder (
        .num1  (r_acc),
        .num2  (in_data),
        .o_sum (w_sum)
    );

    assign w_sum_f     = fp32_t'(w_sum);
    assign w_last_beat = (r_count == (r_len - c_len_one));

`ifdef FP_ACC_RELU_EN
    assign w_result = r_acc[31] ? FP_ZERO : r_acc;
`else
    assign w_result = r_acc;
`endif

    // Outside OUT the last delivered result stays visible
    assign out_data = (r_state == OUT) ? w_result : r_out_hold;
    assign inf_nan  = r_inf_nan;

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (len == '0) ? OUT : ACC;
                end
            end
            ACC: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid && w_last_beat) begin
                    w_next_state = OUT;
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Accumulator, beat counter, sticky overflow flag and result hold register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_acc      <= FP_ZERO;
            r_count    <= '0;
            r_len      <= '0;
            r_inf_nan  <= 1'b0;
            r_out_hold <= FP_ZERO;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len     <= len;
                        r_acc     <= FP_ZERO;
                        r_count   <= '0;
                        r_inf_nan <= 1'b0;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        r_acc   <= w_sum;
                        r_count <= r_count + c_len_one;
                        if (w_sum_f.exp == FP_EXP_MAX) begin
                            r_inf_nan <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_hold <= w_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_accum_ctrl
// Description : Self-checking bench for fp_accum_ctrl: directed vector table,
//               hand-written corner sequences and random vectors compared
//               against a fixed-point truncating-sum reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_accum_ctrl;

    localparam int LEN_W = 10;

    typedef struct packed {
        logic [3:0]   n;
        logic [127:0] e;
        logic [3:0]   gap;
        logic [3:0]   hold;
        logic [31:0]  exp_data;
        logic         exp_inf;
    } vec_t;

    logic             r_clk = 1'b0;
    logic             r_rst_n;
    logic             r_start;
    logic [LEN_W-1:0] r_len;
    logic [31:0]      r_in_data;
    logic             r_in_valid;
    logic             r_out_ready;
    logic             w_busy;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_inf_nan;
    logic [31:0]      w_out_data;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q_in[$];
    vec_t        tbl[7];

    fp_accum_ctrl #(.LEN_W(LEN_W)) dut (
        .Clk       (r_clk),
        .Reset_n   (r_rst_n),
        .start     (r_start),
        .len       (r_len),
        .busy      (w_busy),
        .in_data   (r_in_data),
        .in_valid  (r_in_valid),
        .in_ready  (w_in_ready),
        .out_data  (w_out_data),
        .out_valid (w_out_valid),
        .out_ready (r_out_ready),
        .inf_nan   (w_inf_nan)
    );

    always #5 r_clk = ~r_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef FP_ACC_RELU_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    function automatic vec_t mk(input int n, input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input int gap, input int hold,
                                input logic [31:0] exp_data, input logic exp_inf);
        vec_t v;
        v.n        = 4'(n);
        v.e        = {32'h0, e2, e1, e0};
        v.gap      = 4'(gap);
        v.hold     = 4'(hold);
        v.exp_data = exp_data;
        v.exp_inf  = exp_inf;
        return v;
    endfunction

    // Reference: values as signed integers in units of 2^-30, sum truncated toward zero to 24 bits
    function automatic longint to_fix(input logic [31:0] f);
        longint m;
        if (f[30:23] == 8'd0) return 0;
        m = longint'({1'b1, f[22:0]}) << (int'(f[30:23]) - 120);
        return f[31] ? -m : m;
    endfunction

    function automatic int msb(input longint a);
        for (int i = 62; i >= 0; i--) begin
            if (a[i]) return i;
        end
        return -1;
    endfunction

    function automatic longint trunc24(input longint v);
        longint a;
        int     p;
        a = (v < 0) ? -v : v;
        p = msb(a);
        if (p > 23) a = (a >> (p - 23)) << (p - 23);
        return (v < 0) ? -a : a;
    endfunction

    function automatic logic [31:0] fix_to_fp(input longint v);
        longint      a;
        int          p;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        a = (v < 0) ? -v : v;
        p = msb(a);
        if (p >= 23) m = 32'(a >> (p - 23));
        else         m = 32'(a << (23 - p));
        return {(v < 0), 8'(p - 30 + 127), m[22:0]};
    endfunction

    function automatic logic [31:0] rand_elem();
        logic [31:0] m;
        int          e;
        if ($urandom_range(7) == 0) return 32'h0;
        m = $urandom;
        e = $urandom_range(130, 120);
        return {1'($urandom_range(1)), 8'(e), m[22:0]};
    endfunction

    // One complete vector from q_in: start, beats with optional gaps, held output, handshake
    task automatic run_vec(input string name, input int n, input int gap, input int hold,
                           input logic [31:0] exp_data, input logic exp_inf);
        @(negedge r_clk);
        r_start = 1'b1;
        r_len   = LEN_W'(n);
        @(negedge r_clk);
        r_start = 1'b0;
        check({name, ".busy"}, 32'(w_busy), 32'd1);
        if (n == 0) check({name, ".no_in_ready"}, 32'(w_in_ready), 32'd0);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                r_in_valid = 1'b0;
                r_in_data  = 32'hDEAD_BEEF;
                @(negedge r_clk);
            end
            r_in_valid = 1'b1;
            r_in_data  = q_in[i];
            check({name, ".in_ready"}, 32'(w_in_ready), 32'd1);
            @(negedge r_clk);
            r_in_valid = 1'b0;
        end
        check({name, ".out_valid"}, 32'(w_out_valid), 32'd1);
        check({name, ".out_data"}, w_out_data, exp_data);
        check({name, ".inf_nan"}, 32'(w_inf_nan), 32'(exp_inf));
        for (int h = 0; h < hold; h++) begin
            r_start = (h == 1);
            @(negedge r_clk);
            check({name, ".held_valid"}, 32'(w_out_valid), 32'd1);
            check({name, ".held_data"}, w_out_data, exp_data);
        end
        r_start     = 1'b0;
        r_out_ready = 1'b1;
        @(negedge r_clk);
        r_out_ready = 1'b0;
        check({name, ".done_valid"}, 32'(w_out_valid), 32'd0);
        check({name, ".done_busy"}, 32'(w_busy), 32'd0);
        check({name, ".retained"}, w_out_data, exp_data);
    endtask

    initial begin
        int          n;
        int          gap;
        int          hold;
        longint      acc;
        logic [31:0] e;

        r_rst_n     = 1'b0;
        r_start     = 1'b0;
        r_len       = '0;
        r_in_data   = 32'h0;
        r_in_valid  = 1'b0;
        r_out_ready = 1'b0;

        tbl[0] = mk(3, 32'h3F800000, 32'h40000000, 32'h3F000000, 0, 0, 32'h40600000, 1'b0);
        tbl[1] = mk(0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h00000000, 1'b0);
        tbl[2] = mk(3, 32'h3F800000, 32'h40000000, 32'h3F000000, 3, 0, 32'h40600000, 1'b0);
        tbl[3] = mk(2, 32'h3F800000, 32'hC0400000, 32'h0, 0, 5, relu(32'hC0000000), 1'b0);
        tbl[4] = mk(2, 32'h40400000, 32'hC0400000, 32'h0, 1, 0, 32'h00000000, 1'b0);
        tbl[5] = mk(3, 32'h00000000, 32'h3F800000, 32'h00000000, 0, 1, 32'h3F800000, 1'b0);
        tbl[6] = mk(2, 32'h7F000000, 32'h7F000000, 32'h0, 0, 0, 32'h7F800000, 1'b1);

        repeat (3) @(negedge r_clk);
        check("reset.busy", 32'(w_busy), 32'd0);
        check("reset.in_ready", 32'(w_in_ready), 32'd0);
        check("reset.out_valid", 32'(w_out_valid), 32'd0);
        check("reset.out_data", w_out_data, 32'h0);
        check("reset.inf_nan", 32'(w_inf_nan), 32'd0);
        r_rst_n = 1'b1;

        for (int t = 0; t < 7; t++) begin
            q_in.delete();
            for (int i = 0; i < int'(tbl[t].n); i++) q_in.push_back(tbl[t].e[i*32 +: 32]);
            run_vec($sformatf("tbl%0d", t), int'(tbl[t].n), int'(tbl[t].gap), int'(tbl[t].hold),
                    tbl[t].exp_data, tbl[t].exp_inf);
        end

        // Overflow flag stays set in IDLE and clears on the next accepted start
        check("ovf.sticky_idle", 32'(w_inf_nan), 32'd1);
        @(negedge r_clk);
        r_start = 1'b1;
        r_len   = LEN_W'(1);
        @(negedge r_clk);
        r_start = 1'b0;
        check("ovf.cleared", 32'(w_inf_nan), 32'd0);
        r_in_valid = 1'b1;
        r_in_data  = 32'h3F800000;
        @(negedge r_clk);
        r_in_valid = 1'b0;
        check("ovf.next_data", w_out_data, 32'h3F800000);

        // Start coinciding with the output handshake is dropped
        r_out_ready = 1'b1;
        r_start     = 1'b1;
        r_len       = LEN_W'(2);
        @(negedge r_clk);
        r_out_ready = 1'b0;
        r_start     = 1'b0;
        check("hs_start.busy", 32'(w_busy), 32'd0);
        check("hs_start.out_valid", 32'(w_out_valid), 32'd0);
        @(negedge r_clk);
        check("hs_start.still_idle", 32'(w_busy), 32'd0);

        // Reset in the middle of accumulation discards the partial sum
        r_start = 1'b1;
        r_len   = LEN_W'(4);
        @(negedge r_clk);
        r_start    = 1'b0;
        r_in_valid = 1'b1;
        r_in_data  = 32'h3F800000;
        @(negedge r_clk);
        r_in_data  = 32'h40000000;
        @(negedge r_clk);
        r_in_valid = 1'b0;
        r_rst_n    = 1'b0;
        @(negedge r_clk);
        r_rst_n = 1'b1;
        check("midrst.busy", 32'(w_busy), 32'd0);
        check("midrst.out_valid", 32'(w_out_valid), 32'd0);
        check("midrst.in_ready", 32'(w_in_ready), 32'd0);
        check("midrst.out_data", w_out_data, 32'h0);
        q_in.delete();
        q_in.push_back(32'h41200000);
        run_vec("midrst.fresh", 1, 0, 0, 32'h41200000, 1'b0);

        // Random vectors against the truncating fixed-point reference
        for (int v = 0; v < 40; v++) begin
            n    = $urandom_range(12, 1);
            gap  = $urandom_range(2);
            hold = $urandom_range(3);
            acc  = 0;
            q_in.delete();
            for (int i = 0; i < n; i++) begin
                e = rand_elem();
                q_in.push_back(e);
                acc = trunc24(acc + to_fix(e));
            end
            run_vec($sformatf("rand%0d", v), n, gap, hold, relu(fix_to_fp(acc)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
